rsa_job_ctrl: RTL
=================

Name: rsa_job_ctrl

Overview:
Job sequencer in front of the modular-exponentiation datapath (mon_exp plus its BRAM). Accepts one exponentiation job over a valid/ready handshake and streams preload words (base, R^2 mod n, etc.) into the BRAM's second write port. It then pulses start, waits for stop with a watchdog, and returns ans on a valid/ready result channel. Holds the operand/config buses stable for the whole job.

Parameters:
BITLEN, 512, modulus/exponent width; ans is BITLEN+1 bits
ABITS, 8, BRAM address width
DBITS, 512, BRAM data width
TIMEOUT, 1048576, max cycles in RUN before watchdog abort (>=2)
TW, 21, watchdog counter width (2^TW > TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_n  in  BITLEN  modulus
job_e  in  BITLEN  exponent
job_e_idx  in  10  exponent MSB index
job_mp_count  in  10  Montgomery iteration count
job_nwords  in  ABITS+1  preload word count, 0..2^ABITS
ld_valid  in  1  preload word valid
ld_ready  out  1  high only in LOAD
ld_data  in  DBITS  preload word
bram_wr_addr  out  ABITS  to BRAM WR_ADDR2
bram_wr_data  out  DBITS  to BRAM WR_DATA2
bram_wr_en  out  1  to BRAM WR_EN2
exp_start  out  1  start pulse to datapath
exp_n, exp_e  out  BITLEN  latched job_n / job_e
exp_e_idx, exp_mp_count  out  10  latched job fields
exp_stop  in  1  datapath done
exp_ans  in  BITLEN+1  datapath result
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  BITLEN+1  captured ans (0 on timeout)
res_timeout  out  1  qualifies res_data; 1 = watchdog abort
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, START, RUN, DONE. Reset -> IDLE. All registered outputs reset to 0: exp_*, res_*, busy, address counter, watchdog. job_ready=1 in IDLE; ld_ready=0.
- IDLE: on job_valid & job_ready, latch n/e/e_idx/mp_count into exp_*, clear addr to 0, latch nwords. Next state LOAD if nwords!=0, else START. exp_* stay stable until the next accepted job.
- job_nwords > 2^ABITS: saturate to 2^ABITS.
- LOAD: ld_ready=1. bram_wr_en = ld_valid & ld_ready (combinational, same cycle); bram_wr_addr = addr; bram_wr_data = ld_data. addr increments per handshake. The handshake on word nwords-1 moves to START. ld_valid gaps stall without a write. Outside LOAD, bram_wr_en=0.
- START: exp_start=1 for exactly one cycle; watchdog cleared; -> RUN. The last BRAM write always precedes the start cycle.
- RUN: exp_stop is sampled from the first RUN cycle on. exp_stop=1: res_data<=exp_ans, res_timeout<=0 -> DONE. Otherwise watchdog++. Reaching TIMEOUT-1 with no stop: res_data<=0, res_timeout<=1 -> DONE. Stop in the same cycle as expiry: stop wins (normal result).
- DONE: res_valid=1, res_data/res_timeout held until res_valid & res_ready; then res_valid<=0 -> IDLE. A new job is not accepted in that same cycle (job_ready is registered from state).
- Latency, zero-wait source/sink: accept cycle -> nwords LOAD cycles -> 1 START -> RUN until stop -> res_valid the cycle after stop is sampled.
- rst mid-operation (any state): immediate return to IDLE, outputs cleared, partial result discarded. BRAM contents are not cleared.
- exp_start never asserts outside START; at most one start per accepted job.

Decomposition:
- Shared package: state encoding (3-bit localparams IDLE..DONE), TIMEOUT default, BITLEN/ABITS/DBITS defaults shared with the exponent datapath top.
- One natural sub-module: rsa_watchdog (loadable up-counter with clear, enable and terminal-count flag, width TW).
- FSM, latch registers and load counter stay in rsa_job_ctrl.

Test Plan:
- BITLEN=16, stub datapath raises stop 40 cycles after start with ans=17'h0ABC; job nwords=3, ld words A,B,C -> writes addr 0,1,2 only, single exp_start one cycle after last write, res_valid with res_data=0x0ABC, res_timeout=0.
- nwords=0 -> IDLE->START directly, zero bram_wr_en pulses, result returned normally.
- Stub never stops, TIMEOUT=64 -> res_valid after exactly 64 RUN cycles, res_data=0, res_timeout=1, exp_start pulsed once.
- ld_valid toggling 1,0,0,1,1 with nwords=3 -> writes only on valid cycles at addr 0,1,2. Then res_ready held low 10 cycles -> res_valid/res_data stable, job_ready=0 throughout.
- rst asserted for 1 cycle in LOAD (after 1 word) and again in RUN -> next cycle IDLE, busy=0, res_valid=0, exp_start=0. A subsequent job completes correctly from addr 0.
- Stop coincident with watchdog expiry (stub stop at RUN cycle 64, TIMEOUT=64) -> res_timeout=0, res_data=stub ans.

Source files
------------

// File: rtl/rsa_job_ctrl_pkg.sv
// Shared definitions for the RSA job sequencer and exponent datapath.
// State encoding and default sizing parameters.
package rsa_job_ctrl_pkg;

   localparam int BITLEN_D  = 512;
   localparam int ABITS_D   = 8;
   localparam int DBITS_D   = 512;
   localparam int TIMEOUT_D = 1048576;
   localparam int TW_D      = 21;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_LOAD  = S_LOAD,
      ST_START = S_START,
      ST_RUN   = S_RUN,
      ST_DONE  = S_DONE
   } state_t;

endpackage

// File: rtl/rsa_job_ctrl_watchdog.sv
// Watchdog up-counter with clear, enable and terminal-count flag.
// Terminal count fires when the count reaches TIMEOUT-1.
module rsa_watchdog #(
   parameter int TW      = 21,
   parameter int TIMEOUT = 1048576
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_cnt;

   // count register: clear has priority over enable
   always_ff @(posedge clk) begin
      if (rst)        r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + 1'b1;
   end

   assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/rsa_job_ctrl.sv
// Job sequencer for the modular-exponentiation datapath: accepts a job,
// streams preload words to the BRAM, runs the datapath under a watchdog.
module rsa_job_ctrl
   import rsa_job_ctrl_pkg::*;
#(
   parameter int BITLEN  = BITLEN_D,
   parameter int ABITS   = ABITS_D,
   parameter int DBITS   = DBITS_D,
   parameter int TIMEOUT = TIMEOUT_D,
   parameter int TW      = TW_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [BITLEN-1:0] job_n,
   input  logic [BITLEN-1:0] job_e,
   input  logic [9:0]        job_e_idx,
   input  logic [9:0]        job_mp_count,
   input  logic [ABITS:0]    job_nwords,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DBITS-1:0]  ld_data,
   output logic [ABITS-1:0]  bram_wr_addr,
   output logic [DBITS-1:0]  bram_wr_data,
   output logic              bram_wr_en,
   output logic              exp_start,
   output logic [BITLEN-1:0] exp_n,
   output logic [BITLEN-1:0] exp_e,
   output logic [9:0]        exp_e_idx,
   output logic [9:0]        exp_mp_count,
   input  logic              exp_stop,
   input  logic [BITLEN:0]   exp_ans,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [BITLEN:0]   res_data,
   output logic              res_timeout,
   output logic              busy
);

   localparam logic [ABITS:0] NW_MAX = {1'b1, {ABITS{1'b0}}};
   localparam logic [ABITS:0] NW_ONE = {{ABITS{1'b0}}, 1'b1};

   state_t r_state;
   state_t w_state_nxt;

   logic [BITLEN-1:0] r_exp_n;
   logic [BITLEN-1:0] r_exp_e;
   logic [9:0]        r_exp_e_idx;
   logic [9:0]        r_exp_mp;
   logic [ABITS-1:0]  r_addr;
   logic [ABITS:0]    r_nwords;
   logic [BITLEN:0]   r_res_data;
   logic              r_res_to;

   logic           w_accept;
   logic           w_wr;
   logic           w_last;
   logic           w_wd_clr;
   logic           w_wd_en;
   logic           w_wd_tc;
   logic [ABITS:0] w_nw_sat;

   assign w_nw_sat = (job_nwords > NW_MAX) ? NW_MAX : job_nwords;

   assign job_ready = (r_state == ST_IDLE);
   assign ld_ready  = (r_state == ST_LOAD);
   assign exp_start = (r_state == ST_START);
   assign res_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);

   assign w_accept = job_valid & job_ready;
   assign w_wr     = ld_valid & ld_ready;
   assign w_last   = ({1'b0, r_addr} == (r_nwords - NW_ONE));

   assign bram_wr_en   = w_wr;
   assign bram_wr_addr = r_addr;
   assign bram_wr_data = ld_data;

   assign exp_n        = r_exp_n;
   assign exp_e        = r_exp_e;
   assign exp_e_idx    = r_exp_e_idx;
   assign exp_mp_count = r_exp_mp;
   assign res_data     = r_res_data;
   assign res_timeout  = r_res_to;

   rsa_watchdog #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_wd_clr),
      .i_en  (w_wd_en),
      .o_tc  (w_wd_tc)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next state and watchdog control
   always_comb begin
      w_state_nxt = r_state;
      w_wd_clr    = 1'b0;
      w_wd_en     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (job_valid)
               w_state_nxt = (w_nw_sat != '0) ? ST_LOAD : ST_START;
         end
         ST_LOAD: begin
            if (ld_valid && w_last) w_state_nxt = ST_START;
         end
         ST_START: begin
            w_wd_clr    = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (exp_stop || w_wd_tc) w_state_nxt = ST_DONE;
            else                     w_wd_en     = 1'b1;
         end
         ST_DONE: begin
            if (res_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // job latches, load address counter and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp_n     <= '0;
         r_exp_e     <= '0;
         r_exp_e_idx <= '0;
         r_exp_mp    <= '0;
         r_addr      <= '0;
         r_nwords    <= '0;
         r_res_data  <= '0;
         r_res_to    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_exp_n     <= job_n;
            r_exp_e     <= job_e;
            r_exp_e_idx <= job_e_idx;
            r_exp_mp    <= job_mp_count;
            r_addr      <= '0;
            r_nwords    <= w_nw_sat;
         end
         if (w_wr) r_addr <= r_addr + 1'b1;
         if (r_state == ST_RUN) begin
            if (exp_stop) begin
               r_res_data <= exp_ans;
               r_res_to   <= 1'b0;
            end else if (w_wd_tc) begin
               r_res_data <= '0;
               r_res_to   <= 1'b1;
            end
         end
      end
   end

endmodule
